// File: rtl/ef_in_pacer.sv
// ef_in_pacer: paces an irregular upstream sample stream into the folded equalizer.
// Samples are buffered in a small circular FIFO and released one at a time, no
// faster than one every PERIOD cycles (the equalizer frame length).
//
// Parameters:
//   DI_W   - sample width (signed Q2.5 by default; data is passed through untouched)
//   DEPTH  - FIFO depth in samples, power of two, >= 2
//   PERIOD - minimum spacing in cycles between issues, >= 2
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - upstream sample strobe
//   in_data   - upstream sample
//   in_ready  - FIFO has room (level < DEPTH); ignores a same-cycle pop
//   out_valid - registered single-cycle issue strobe (equalizer valid_i)
//   out_data  - registered issued sample, held between issues (equalizer data_i)
//   level     - registered FIFO occupancy, 0..DEPTH
//   overflow  - registered sticky flag, set when a sample is dropped on a full FIFO
//   clr_ovf   - synchronous clear of overflow; a same-edge drop wins
module ef_in_pacer #(
  parameter int unsigned DI_W   = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PERIOD = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DI_W-1:0]            in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DI_W-1:0]            out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned GapW = $clog2(PERIOD);

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("ef_in_pacer: DEPTH must be a power of two and at least 2");
  end
  if (PERIOD < 2) begin : gen_bad_period
    $error("ef_in_pacer: PERIOD must be at least 2");
  end

  typedef enum logic [0:0] {StIdle, StGap} state_e;

  state_e                state_q, state_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic [DI_W-1:0]       out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic [DI_W-1:0]       mem_q [DEPTH];

  logic                  wr_en;
  logic                  drop;
  logic                  issue;

  // Room is judged on the registered level only, so a full FIFO rejects a write
  // even on the edge where it also issues.
  assign in_ready = (level_q < LvlW'(DEPTH));
  assign wr_en    = in_valid & in_ready;
  assign drop     = in_valid & ~in_ready;
  assign issue    = (state_q == StIdle) && (level_q != '0);

  // Pacing FSM: IDLE issues as soon as a sample is buffered, GAP counts out the
  // remainder of the frame so consecutive issues land exactly PERIOD cycles apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          gap_d   = GapW'(PERIOD - 1);
          state_d = StGap;
        end
      end
      StGap: begin
        gap_d = gap_q - GapW'(1);
        if (gap_d == '0) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // FIFO pointers, occupancy and output registers.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = issue;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;

    // DEPTH is a power of two, so natural pointer overflow gives the wrap.
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (issue) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      out_data_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_en, issue})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    // Set beats clear when both happen on one edge.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read after being written, and a
  // reset empties the FIFO by clearing the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

`ifndef SYNTHESIS
  a_level_range : assert property (@(posedge clk) disable iff (rst) level_q <= LvlW'(DEPTH));
  a_idle_gap    : assert property (@(posedge clk) disable iff (rst)
                                   (state_q == StIdle) |-> (gap_q == '0));
  a_gap_nonzero : assert property (@(posedge clk) disable iff (rst)
                                   (state_q == StGap) |-> (gap_q != '0));
`endif

endmodule

// File: tb/tb_ef_in_pacer.sv
module tb_ef_in_pacer;

  localparam int unsigned DI_W   = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PERIOD = 20;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [DI_W-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic [DI_W-1:0] out_data;
  logic [3:0]      level;
  logic            overflow;
  logic            clr_ovf;

  ef_in_pacer #(
    .DI_W  (DI_W),
    .DEPTH (DEPTH),
    .PERIOD(PERIOD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DI_W-1:0] m_fifo [$];
  logic [DI_W-1:0] exp_q  [$];
  int              m_gap  = 0;
  logic            m_ovf  = 1'b0;
  logic            m_ov   = 1'b0;
  logic [DI_W-1:0] m_last = '0;
  int              edge_n = 0;
  int              last_pulse = 0;
  logic            have_last = 1'b0;
  int              pulse_q [$];
  int              peak_level = 0;

  typedef struct {
    logic            v;
    logic [DI_W-1:0] d;
    logic            c;
    logic            ov;
    logic [DI_W-1:0] od;
    logic [3:0]      lvl;
    logic            ovf;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_outputs();
    logic [DI_W-1:0] e;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("level", 32'(level), 32'(m_fifo.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("in_ready", 32'(in_ready), 32'(m_fifo.size() < DEPTH));
    if (32'(level) > peak_level) peak_level = 32'(level);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: out_valid with no expected sample (edge %0d)", edge_n);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e));
      end
      if (have_last) check("spacing_ok", 32'((edge_n - last_pulse) >= PERIOD), 32'd1);
      have_last  = 1'b1;
      last_pulse = edge_n;
      pulse_q.push_back(edge_n);
    end else begin
      check("out_data_hold", 32'(out_data), 32'(m_last));
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, check #1 later.
  task automatic step(input logic v, input logic [DI_W-1:0] d, input logic c);
    logic iss;
    logic wr;
    in_valid = v;
    in_data  = d;
    clr_ovf  = c;
    iss = (m_gap == 0) && (m_fifo.size() != 0);
    wr  = v && (m_fifo.size() < DEPTH);
    @(posedge clk);
    if (m_gap != 0) begin
      m_gap = m_gap - 1;
    end else if (iss) begin
      m_last = m_fifo.pop_front();
      m_gap  = PERIOD - 1;
    end
    if (wr) begin
      m_fifo.push_back(d);
      exp_q.push_back(d);
    end
    if (v && !wr) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_ov = iss;
    #1;
    edge_n++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_gap     = 0;
    m_ovf     = 1'b0;
    m_ov      = 1'b0;
    m_last    = '0;
    have_last = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    clr_ovf  = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset_values("rst_async");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_values("rst_release");
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clr_ovf  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    #1;

    // Single sample, then a write during GAP.
    tbl[0] = '{1'b1, 8'h15, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h15, 4'd0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h15, 4'd0, 1'b0};
    tbl[3] = '{1'b1, 8'h2a, 1'b0, 1'b0, 8'h15, 4'd1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h15, 4'd1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h15, 4'd1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ov));
      check("tbl_out_data", 32'(out_data), 32'(tbl[i].od));
      check("tbl_level", 32'(level), 32'(tbl[i].lvl));
      check("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
    end
    idle(15);                       // edges 6..20, still in GAP
    step(1'b0, '0, 1'b0);           // edge 21: second issue
    check("gap_issue_valid", 32'(out_valid), 32'd1);
    check("gap_issue_data", 32'(out_data), 32'h2a);
    idle(25);

    // Burst of five: pulses at edges 1, 21, 41, 61, 81 relative to the first write.
    do_reset();
    pulse_q.delete();
    peak_level = 0;
    base = edge_n + 1;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    idle(100);
    check("burst_pulses", 32'(pulse_q.size()), 32'd5);
    for (int i = 0; i < pulse_q.size() && i < 5; i++)
      check("burst_pulse_edge", 32'(pulse_q[i] - base), 32'(1 + PERIOD * i));
    check("burst_peak_level", 32'(peak_level), 32'd4);

    // Overflow: issue one, then ten back-to-back writes during GAP.
    do_reset();
    step(1'b1, 8'h80, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_full_level", 32'(level), 32'd8);
    check("ovf_full_ready", 32'(in_ready), 32'd0);
    step(1'b0, '0, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);
    // Clear and drop on the same edge: the drop wins.
    step(1'b1, 8'hee, 1'b1);
    check("ovf_collision", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b1);
    // Keep the FIFO full across the next issue edge: that write must still drop.
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hc0 + i), 1'b0);
    idle(200);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);

    // Pointer wrap: 20 samples at one per PERIOD cycles.
    do_reset();
    pulse_q.delete();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h40 + 3 * i), 1'b0);
      idle(PERIOD - 1);
    end
    idle(5);
    check("wrap_issued", 32'(pulse_q.size()), 32'd20);
    check("wrap_no_ovf", 32'(overflow), 32'd0);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-GAP with samples still buffered.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h31 + i), 1'b0);
    idle(7);
    check("pre_rst_level", 32'(level), 32'd2);
    do_reset();
    pulse_q.delete();
    idle(30);
    check("post_rst_no_pulse", 32'(pulse_q.size()), 32'd0);
    step(1'b1, 8'h5a, 1'b0);
    check("post_rst_write_level", 32'(level), 32'd1);
    step(1'b0, '0, 1'b0);
    check("post_rst_issue_valid", 32'(out_valid), 32'd1);
    check("post_rst_issue_data", 32'(out_data), 32'h5a);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
